sprite_render: RTL and testbench

SPRITE_RENDER -- requirements
Module: sprite_render

---
 rtl/sprite_pkg.sv | 20 ++
 rtl/sprite_anim_fsm.sv | 72 +++++++
 rtl/sprite_render.sv | 96 +++++++++
 tb/tb_sprite_render.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and the animation state type for the sprite renderer.
// The ROM holds four 20x40 frames of 4-bit palette indices.
package sprite_pkg;

  localparam int SPR_W           = 20;
  localparam int SPR_H           = 40;
  localparam int SPR_FRAME_WORDS = 800;
  localparam int GROUND_Y        = 378;
  localparam int WALK_PERIOD     = 5;

  localparam logic [3:0] TRANSPARENT_IDX = 4'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK_A = 2'd1,
    WALK_B = 2'd2,
    JUMP   = 2'd3
  } anim_state_t;

endpackage

// File: rtl/sprite_anim_fsm.sv
// Animation state machine and walk counter.
// Advances only on a frame edge, comparing the incoming ball position against the latched one.
module sprite_anim_fsm
  import sprite_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_edge,
  input  logic [9:0] new_x,
  input  logic [9:0] new_y,
  input  logic [9:0] prev_x,
  output logic [1:0] anim_frame
);

  anim_state_t state, state_next;
  logic [2:0]  count, count_next;
  logic        x_moved;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      count <= 3'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Leaving the ground overrides every walk rule.
  always_comb begin
    state_next = state;
    count_next = count;
    x_moved    = (new_x != prev_x);
    if (frame_edge) begin
      if (new_y < 10'(GROUND_Y)) begin
        state_next = JUMP;
        count_next = 3'd0;
      end else begin
        case (state)
          IDLE: begin
            state_next = x_moved ? WALK_A : IDLE;
            count_next = 3'd0;
          end
          WALK_A, WALK_B: begin
            if (x_moved) begin
              if (count == 3'(WALK_PERIOD - 1)) begin
                count_next = 3'd0;
                state_next = (state == WALK_A) ? WALK_B : WALK_A;
              end else begin
                count_next = count + 3'd1;
              end
            end else begin
              state_next = IDLE;
              count_next = 3'd0;
            end
          end
          JUMP: begin
            state_next = x_moved ? WALK_A : IDLE;
            count_next = 3'd0;
          end
          default: begin
            state_next = IDLE;
            count_next = 3'd0;
          end
        endcase
      end
    end
  end

  assign anim_frame = state;

endmodule

// File: rtl/sprite_render.sv
// Sprite renderer: per-frame shadow latch, bounding-box hit test, ROM addressing
// and a hit flag that travels alongside the ROM read.
module sprite_render
  import sprite_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        vsync,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  input  logic [9:0]  BallSX,
  input  logic [9:0]  BallSY,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  output logic [11:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic        pixel_on,
  output logic [3:0]  pixel_idx,
  output logic [1:0]  anim_frame
);

  logic       vsync_q;
  logic       frame_edge;
  logic [9:0] shadow_x, shadow_y, shadow_sx, shadow_sy;

  logic signed [11:0] box_left, box_top, box_right, box_bottom;
  logic signed [11:0] px, py, col, row;
  logic               in_box, hit;
  logic [11:0]        addr_calc;
  logic               hit_d1, hit_d2;

  assign frame_edge = vsync & ~vsync_q;

  // Rendering only ever sees the shadow copy, so the ball cannot tear mid-frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vsync_q   <= 1'b0;
      shadow_x  <= 10'd0;
      shadow_y  <= 10'd0;
      shadow_sx <= 10'd0;
      shadow_sy <= 10'd0;
    end else begin
      vsync_q <= vsync;
      if (frame_edge) begin
        shadow_x  <= BallX;
        shadow_y  <= BallY;
        shadow_sx <= BallSX;
        shadow_sy <= BallSY;
      end
    end
  end

  sprite_anim_fsm u_anim (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_edge (frame_edge),
    .new_x      (BallX),
    .new_y      (BallY),
    .prev_x     (shadow_x),
    .anim_frame (anim_frame)
  );

  // Box edges carry two guard bits so X+SX never wraps and X-SX may go negative.
  always_comb begin
    box_left   = $signed({2'b00, shadow_x}) - $signed({2'b00, shadow_sx});
    box_top    = $signed({2'b00, shadow_y}) - $signed({2'b00, shadow_sy});
    box_right  = $signed({2'b00, shadow_x}) + $signed({2'b00, shadow_sx});
    box_bottom = $signed({2'b00, shadow_y}) + $signed({2'b00, shadow_sy});
    px         = $signed({2'b00, DrawX});
    py         = $signed({2'b00, DrawY});
    col        = px - box_left;
    row        = py - box_top;
    in_box     = (px >= box_left) && (px < box_right) &&
                 (py >= box_top)  && (py < box_bottom) && blank;
    hit        = in_box && (col < $signed(12'(SPR_W))) && (row < $signed(12'(SPR_H)));
    addr_calc  = 12'(anim_frame) * 12'(SPR_FRAME_WORDS) +
                 12'(row) * 12'(SPR_W) + 12'(col);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit_d1   <= 1'b0;
      hit_d2   <= 1'b0;
      rom_addr <= 12'd0;
    end else begin
      hit_d1   <= hit;
      hit_d2   <= hit_d1;
      rom_addr <= hit ? addr_calc : 12'd0;
    end
  end

  assign pixel_on  = hit_d2 && (rom_data != TRANSPARENT_IDX);
  assign pixel_idx = pixel_on ? rom_data : TRANSPARENT_IDX;

endmodule

// File: tb/tb_sprite_render.sv
// Self-checking bench for sprite_render: constant pixel vectors, fixed walk/jump/reset
// sequences and randomized frames checked against a plain-integer reference model.
module tb_sprite_render;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic [9:0]  ball_x, ball_y, ball_sx, ball_sy;
  logic [9:0]  draw_x, draw_y;
  logic        blank;
  logic [11:0] rom_addr;
  logic [3:0]  rom_data;
  logic        pixel_on;
  logic [3:0]  pixel_idx;
  logic [1:0]  anim_frame;

  logic [3:0]  rom [4096];

  int n_checks = 0;
  int n_fail   = 0;

  int m_x, m_y, m_sx, m_sy, m_state, m_cnt;

  typedef struct {
    string name;
    int    dx;
    int    dy;
    int    bl;
    int    exp_hit;
    int    exp_addr;
  } pix_vec_t;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  sprite_render dut (
    .Clk        (clk),
    .Reset      (reset),
    .vsync      (vsync),
    .BallX      (ball_x),
    .BallY      (ball_y),
    .BallSX     (ball_sx),
    .BallSY     (ball_sy),
    .DrawX      (draw_x),
    .DrawY      (draw_y),
    .blank      (blank),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pixel_on   (pixel_on),
    .pixel_idx  (pixel_idx),
    .anim_frame (anim_frame)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_sx = 0; m_sy = 0; m_state = 0; m_cnt = 0;
  endtask

  // Frame-boundary behaviour straight from the animation rules.
  task automatic model_vsync(input int x, input int y, input int sx, input int sy);
    bit moved;
    moved = (x != m_x);
    if (y < 378) begin
      m_state = 3; m_cnt = 0;
    end else if (m_state == 1 || m_state == 2) begin
      if (moved) begin
        m_cnt++;
        if (m_cnt == 5) begin
          m_cnt = 0;
          m_state = (m_state == 1) ? 2 : 1;
        end
      end else begin
        m_state = 0; m_cnt = 0;
      end
    end else begin
      m_state = moved ? 1 : 0;
      m_cnt = 0;
    end
    m_x = x; m_y = y; m_sx = sx; m_sy = sy;
  endtask

  task automatic ref_pixel(input int dx, input int dy, input int bl,
                           output int hit, output int addr);
    int l, t, c, r;
    l = m_x - m_sx;
    t = m_y - m_sy;
    c = dx - l;
    r = dy - t;
    hit = (bl != 0 && dx >= l && dx < m_x + m_sx && dy >= t && dy < m_y + m_sy &&
           c < 20 && r < 40) ? 1 : 0;
    addr = hit ? (m_state * 800 + r * 20 + c) : 0;
  endtask

  task automatic do_vsync(input int x, input int y, input int sx, input int sy);
    ball_x = 10'(x); ball_y = 10'(y); ball_sx = 10'(sx); ball_sy = 10'(sy);
    blank = 1'b0; draw_x = 10'd0; draw_y = 10'd0;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    model_vsync(x, y, sx, sy);
    tick();
  endtask

  task automatic apply_stimulus(input int dx, input int dy, input int bl);
    draw_x = 10'(dx); draw_y = 10'(dy); blank = bl[0];
  endtask

  // Address one cycle after the pixel, pixel outputs one cycle after that.
  task automatic check_pixel(input string name, input int dx, input int dy, input int bl,
                             input int exp_hit, input int exp_addr);
    int exp_on;
    apply_stimulus(dx, dy, bl);
    tick();
    check_output({name, "_addr"}, int'(rom_addr), exp_addr);
    apply_stimulus(0, 0, 0);
    tick();
    exp_on = (exp_hit != 0 && rom[exp_addr] != 4'd0) ? 1 : 0;
    check_output({name, "_on"}, int'(pixel_on), exp_on);
    check_output({name, "_idx"}, int'(pixel_idx), exp_on ? int'(rom[exp_addr]) : 0);
  endtask

  task automatic check_model_pixel(input string name, input int dx, input int dy, input int bl);
    int h, a;
    ref_pixel(dx, dy, bl, h, a);
    check_pixel(name, dx, dy, bl, h, a);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pix_vec_t vecs[8];
    int walk_seq[12];
    int cur_x, ny, nsx, nsy, h, a;
    int s_hit[128];
    int s_addr[128];

    vecs[0] = '{"origin",    70, 364, 1, 1, 0};
    vecs[1] = '{"col19",     89, 364, 1, 1, 19};
    vecs[2] = '{"right_out", 90, 364, 1, 0, 0};
    vecs[3] = '{"left_out",  69, 364, 1, 0, 0};
    vecs[4] = '{"row39",     70, 403, 1, 1, 780};
    vecs[5] = '{"bottom_out",70, 404, 1, 0, 0};
    vecs[6] = '{"blanked",   75, 370, 0, 0, 0};
    vecs[7] = '{"centre",    79, 383, 1, 1, 389};
    walk_seq = '{1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 1, 1};

    for (int i = 0; i < 4096; i++) rom[i] = 4'($urandom);

    reset = 1'b1; vsync = 1'b0;
    ball_x = 10'd0; ball_y = 10'd0; ball_sx = 10'd0; ball_sy = 10'd0;
    apply_stimulus(0, 0, 0);
    tick();
    tick();
    model_reset();
    check_output("rst_addr",  int'(rom_addr),   0);
    check_output("rst_on",    int'(pixel_on),   0);
    check_output("rst_idx",   int'(pixel_idx),  0);
    check_output("rst_frame", int'(anim_frame), 0);
    reset = 1'b0;
    tick();

    $display("[TB] no hit before first latch");
    check_pixel("prelatch", 0, 0, 1, 0, 0);

    $display("[TB] static sprite at (80,384) size 10x20");
    do_vsync(80, 384, 10, 20);
    check_output("first_latch_frame", int'(anim_frame), 1);
    do_vsync(80, 384, 10, 20);
    check_output("still_frame", int'(anim_frame), 0);

    rom[0] = 4'hF;
    for (int i = 0; i < 8; i++)
      check_pixel(vecs[i].name, vecs[i].dx, vecs[i].dy, vecs[i].bl,
                  vecs[i].exp_hit, vecs[i].exp_addr);

    rom[25] = 4'd0;
    check_pixel("transp0", 75, 365, 1, 1, 25);
    rom[26] = 4'd7;
    check_pixel("opaque7", 76, 365, 1, 1, 26);

    $display("[TB] walk sequence");
    for (int i = 0; i < 12; i++) begin
      do_vsync(81 + i, 384, 10, 20);
      check_output($sformatf("walk%0d", i), int'(anim_frame), walk_seq[i]);
      if (i == 7) check_pixel("walkb_addr", 80, 370, 1, 1, 1722);
    end
    do_vsync(92, 384, 10, 20);
    check_output("walk_stop", int'(anim_frame), 0);

    $display("[TB] jump");
    do_vsync(80, 300, 10, 20);
    check_output("jump_frame", int'(anim_frame), 3);
    check_pixel("jump_addr", 73, 285, 1, 1, 2503);

    $display("[TB] randomized frames");
    cur_x = 400;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) != 0) cur_x = cur_x + int'($urandom_range(1, 3));
      if (cur_x > 900) cur_x = 100;
      ny  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(250, 377))
                                        : int'($urandom_range(378, 420));
      nsx = int'($urandom_range(1, 14));
      nsy = int'($urandom_range(1, 25));
      do_vsync(cur_x, ny, nsx, nsy);
      check_output($sformatf("rand_frame%0d", i), int'(anim_frame), m_state);
      if (i % 6 == 0)
        check_model_pixel($sformatf("rand_pix%0d", i),
                          cur_x - nsx + int'($urandom_range(0, 2 * nsx)),
                          ny - nsy + int'($urandom_range(0, 2 * nsy)), 1);
    end

    $display("[TB] back-to-back pixel stream with clipping");
    do_vsync(500, 450, 12, 25);
    for (int k = 0; k < 100; k++) begin
      int dx, dy, bl;
      dx = 485 + int'($urandom_range(0, 30));
      dy = 420 + int'($urandom_range(0, 60));
      bl = ($urandom_range(0, 7) != 0) ? 1 : 0;
      ref_pixel(dx, dy, bl, h, a);
      s_hit[k] = h;
      s_addr[k] = a;
      apply_stimulus(dx, dy, bl);
      tick();
      check_output($sformatf("stream_addr%0d", k), int'(rom_addr), s_addr[k]);
      if (k > 0)
        check_output($sformatf("stream_on%0d", k), int'(pixel_on),
                     (s_hit[k-1] != 0 && rom[s_addr[k-1]] != 4'd0) ? 1 : 0);
    end
    apply_stimulus(0, 0, 0);
    tick();

    $display("[TB] shadow hold and mid-frame reset");
    do_vsync(200, 384, 10, 20);
    do_vsync(200, 384, 10, 20);
    do_vsync(201, 384, 10, 20);
    check_output("pre_rst_frame", int'(anim_frame), 1);
    ball_x = 10'd500;
    rom[1210] = 4'd9;
    check_pixel("no_tear", 201, 384, 1, 1, 1210);
    apply_stimulus(201, 384, 1);
    tick();
    tick();
    check_output("pre_rst_on", int'(pixel_on), 1);
    reset = 1'b1;
    tick();
    model_reset();
    check_output("midrst_addr",  int'(rom_addr),   0);
    check_output("midrst_on",    int'(pixel_on),   0);
    check_output("midrst_idx",   int'(pixel_idx),  0);
    check_output("midrst_frame", int'(anim_frame), 0);
    reset = 1'b0;
    ball_x = 10'd300;
    tick();
    check_pixel("post_rst", 201, 384, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
